// File: rtl/clear_global_lvl_states_pkg.sv
// rtl/clear_global_lvl_states_pkg.sv - shared encodings and widths for the backtrack level-state clear path
package clear_global_lvl_states_pkg;

  localparam int DEF_WIDTH_LVL              = 16;
  localparam int DEF_WIDTH_BIN_ID           = 10;
  localparam int DEF_WIDTH_LVL_STATES       = DEF_WIDTH_BIN_ID + 1;
  localparam int DEF_ADDR_WIDTH_LVLS_STATES = 9;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_CLEAR = 2'd1,
    ST_DONE  = 2'd2
  } clr_state_e;

  typedef struct packed {
    logic [DEF_WIDTH_BIN_ID-1:0] dcd_bin;
    logic                        has_bkt;
  } lvl_state_t;

  function automatic lvl_state_t pack_lvl_state(logic [DEF_WIDTH_BIN_ID-1:0] dcd_bin, logic has_bkt);
    lvl_state_t s;
    s.dcd_bin = dcd_bin;
    s.has_bkt = has_bkt;
    return s;
  endfunction

endpackage

// File: rtl/clear_global_lvl_states.sv
// rtl/clear_global_lvl_states.sv - zeroes lvl-states entries above the backtrack level; optional LVL_CLR_CNT_EN adds clr_cnt_o
module clear_global_lvl_states
  import clear_global_lvl_states_pkg::*;
#(
  parameter int WIDTH_LVL              = DEF_WIDTH_LVL,
  parameter int WIDTH_BIN_ID           = DEF_WIDTH_BIN_ID,
  parameter int WIDTH_LVL_STATES       = DEF_WIDTH_LVL_STATES,
  parameter int ADDR_WIDTH_LVLS_STATES = DEF_ADDR_WIDTH_LVLS_STATES
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              start_clear,
  input  logic [WIDTH_LVL-1:0]              cur_lvl_i,
  input  logic [WIDTH_LVL-1:0]              bkt_lvl_i,
  input  logic [WIDTH_BIN_ID-1:0]           bkt_bin_i,
  output logic                              apply_clear_o,
  output logic                              done_clear,
  output logic [WIDTH_LVL-1:0]              cur_lvl_o,
  output logic [WIDTH_BIN_ID-1:0]           load_bin_o,
  output logic                              lvl_ovf_o,
  output logic                              ram_we_ls_o,
  output logic [ADDR_WIDTH_LVLS_STATES-1:0] ram_waddr_ls_o,
  output logic [WIDTH_LVL_STATES-1:0]       ram_wdata_ls_o
`ifdef LVL_CLR_CNT_EN
  ,output logic [WIDTH_LVL-1:0]             clr_cnt_o
`endif
);

  clr_state_e                        state_q, state_d;
  logic [WIDTH_LVL-1:0]              lvl_cnt_q, lvl_cnt_d;
  logic [WIDTH_LVL-1:0]              bkt_lvl_q, bkt_lvl_d;
  logic [WIDTH_BIN_ID-1:0]           bkt_bin_q, bkt_bin_d;
  logic [WIDTH_LVL-1:0]              cur_lvl_q, cur_lvl_d;
  logic [WIDTH_BIN_ID-1:0]           load_bin_q, load_bin_d;
  logic                              ovf_q, ovf_d;
  logic                              apply_q, apply_d;
  logic                              done_q, done_d;
  logic                              we_q, we_d;
  logic [ADDR_WIDTH_LVLS_STATES-1:0] waddr_q, waddr_d;
  logic [WIDTH_LVL_STATES-1:0]       wdata_q, wdata_d;

  always_comb begin
    state_d    = state_q;
    lvl_cnt_d  = lvl_cnt_q;
    bkt_lvl_d  = bkt_lvl_q;
    bkt_bin_d  = bkt_bin_q;
    cur_lvl_d  = cur_lvl_q;
    load_bin_d = load_bin_q;
    ovf_d      = ovf_q;
    // Write strobe and mux request share one term so they never skew.
    we_d       = (state_q == ST_CLEAR);
    apply_d    = (state_q == ST_CLEAR);
    waddr_d    = (state_q == ST_CLEAR) ? lvl_cnt_q[ADDR_WIDTH_LVLS_STATES-1:0] : '0;
    wdata_d    = WIDTH_LVL_STATES'(pack_lvl_state('0, 1'b0));
    done_d     = (state_q == ST_DONE);

    case (state_q)
      ST_IDLE: begin
        if (start_clear) begin
          lvl_cnt_d = cur_lvl_i;
          bkt_lvl_d = bkt_lvl_i;
          bkt_bin_d = bkt_bin_i;
          if (|(cur_lvl_i >> ADDR_WIDTH_LVLS_STATES)) ovf_d = 1'b1;
          state_d = (cur_lvl_i > bkt_lvl_i) ? ST_CLEAR : ST_DONE;
        end
      end
      ST_CLEAR: begin
        // Stop one above the backtrack level so its has_bkt entry survives.
        if (lvl_cnt_q == bkt_lvl_q + WIDTH_LVL'(1)) state_d = ST_DONE;
        else lvl_cnt_d = lvl_cnt_q - WIDTH_LVL'(1);
      end
      ST_DONE: begin
        cur_lvl_d  = bkt_lvl_q;
        load_bin_d = bkt_bin_q;
        state_d    = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q    <= ST_IDLE;
      lvl_cnt_q  <= '0;
      bkt_lvl_q  <= '0;
      bkt_bin_q  <= '0;
      cur_lvl_q  <= '0;
      load_bin_q <= '0;
      ovf_q      <= 1'b0;
      apply_q    <= 1'b0;
      done_q     <= 1'b0;
      we_q       <= 1'b0;
      waddr_q    <= '0;
      wdata_q    <= '0;
    end else begin
      state_q    <= state_d;
      lvl_cnt_q  <= lvl_cnt_d;
      bkt_lvl_q  <= bkt_lvl_d;
      bkt_bin_q  <= bkt_bin_d;
      cur_lvl_q  <= cur_lvl_d;
      load_bin_q <= load_bin_d;
      ovf_q      <= ovf_d;
      apply_q    <= apply_d;
      done_q     <= done_d;
      we_q       <= we_d;
      waddr_q    <= waddr_d;
      wdata_q    <= wdata_d;
    end
  end

  assign apply_clear_o  = apply_q;
  assign done_clear     = done_q;
  assign cur_lvl_o      = cur_lvl_q;
  assign load_bin_o     = load_bin_q;
  assign lvl_ovf_o      = ovf_q;
  assign ram_we_ls_o    = we_q;
  assign ram_waddr_ls_o = waddr_q;
  assign ram_wdata_ls_o = wdata_q;

`ifdef LVL_CLR_CNT_EN
  logic [WIDTH_LVL-1:0] clr_cnt_q, clr_cnt_d;

  always_comb begin
    clr_cnt_d = clr_cnt_q;
    if (we_q && (clr_cnt_q != '1)) clr_cnt_d = clr_cnt_q + WIDTH_LVL'(1);
  end

  always_ff @(posedge clk) begin
    if (!rst) clr_cnt_q <= '0;
    else      clr_cnt_q <= clr_cnt_d;
  end

  assign clr_cnt_o = clr_cnt_q;
`endif

endmodule

// File: tb/tb_clear_global_lvl_states.sv
// tb/tb_clear_global_lvl_states.sv - directed table-driven bench for clear_global_lvl_states
module tb_clear_global_lvl_states;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        start_clear = 1'b0;
  logic [15:0] cur_lvl_i = '0;
  logic [15:0] bkt_lvl_i = '0;
  logic [9:0]  bkt_bin_i = '0;
  logic        apply_clear_o;
  logic        done_clear;
  logic [15:0] cur_lvl_o;
  logic [9:0]  load_bin_o;
  logic        lvl_ovf_o;
  logic        ram_we_ls_o;
  logic [8:0]  ram_waddr_ls_o;
  logic [10:0] ram_wdata_ls_o;
`ifdef LVL_CLR_CNT_EN
  logic [15:0] clr_cnt_o;
`endif

  clear_global_lvl_states dut (
    .clk            (clk),
    .rst            (rst),
    .start_clear    (start_clear),
    .cur_lvl_i      (cur_lvl_i),
    .bkt_lvl_i      (bkt_lvl_i),
    .bkt_bin_i      (bkt_bin_i),
    .apply_clear_o  (apply_clear_o),
    .done_clear     (done_clear),
    .cur_lvl_o      (cur_lvl_o),
    .load_bin_o     (load_bin_o),
    .lvl_ovf_o      (lvl_ovf_o),
    .ram_we_ls_o    (ram_we_ls_o),
    .ram_waddr_ls_o (ram_waddr_ls_o),
    .ram_wdata_ls_o (ram_wdata_ls_o)
`ifdef LVL_CLR_CNT_EN
    ,.clr_cnt_o     (clr_cnt_o)
`endif
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input longint act, input longint exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  typedef struct {
    int cur; int bkt; int bin; int extra_cyc;
    int nwr; int first_addr; int last_addr; int done_cyc;
    int cur_o; int bin_o; int ovf;
  } vec_t;

  // Results of the most recent run_op
  int r_nwr, r_first, r_last, r_addr_err, r_data_err, r_apply_err, r_done_cyc, r_done_cnt;

  task automatic run_op(input int cur, input int bkt, input int bin, input int extra_cyc);
    int k;
    k = 0;
    r_nwr = 0; r_first = -1; r_last = -1; r_addr_err = 0; r_data_err = 0;
    r_apply_err = 0; r_done_cyc = -1; r_done_cnt = 0;
    for (int c = 0; c < 60; c++) begin
      @(negedge clk);
      if (c > 0) begin
        if (apply_clear_o !== ram_we_ls_o) r_apply_err++;
        if (ram_we_ls_o) begin
          if (r_first < 0) r_first = int'(ram_waddr_ls_o);
          r_last = int'(ram_waddr_ls_o);
          if (int'(ram_waddr_ls_o) != ((cur - k) & 511) || c != 2 + k) r_addr_err++;
          if (ram_wdata_ls_o !== 11'd0) r_data_err++;
          k++;
          r_nwr++;
        end else if (ram_waddr_ls_o !== 9'd0 || ram_wdata_ls_o !== 11'd0) begin
          r_data_err++;
        end
        if (done_clear) begin
          r_done_cnt++;
          if (r_done_cyc < 0) r_done_cyc = c;
        end
        if (r_done_cyc >= 0 && c >= r_done_cyc + 3) break;
      end
      if (c == 0) begin
        start_clear = 1'b1;
        cur_lvl_i = 16'(cur); bkt_lvl_i = 16'(bkt); bkt_bin_i = 10'(bin);
      end else if (c == extra_cyc) begin
        start_clear = 1'b1;
        cur_lvl_i = 16'd20; bkt_lvl_i = 16'd15; bkt_bin_i = 10'd99;
      end else begin
        start_clear = 1'b0;
      end
    end
    start_clear = 1'b0;
  endtask

  vec_t vecs[8];

  initial begin
    vecs[0] = '{cur:5,     bkt:2,     bin:7,  extra_cyc:-1, nwr:3,  first_addr:5,  last_addr:3,  done_cyc:5,  cur_o:2,     bin_o:7,  ovf:0};
    vecs[1] = '{cur:3,     bkt:3,     bin:9,  extra_cyc:-1, nwr:0,  first_addr:-1, last_addr:-1, done_cyc:2,  cur_o:3,     bin_o:9,  ovf:0};
    vecs[2] = '{cur:1,     bkt:0,     bin:4,  extra_cyc:-1, nwr:1,  first_addr:1,  last_addr:1,  done_cyc:3,  cur_o:0,     bin_o:4,  ovf:0};
    vecs[3] = '{cur:10,    bkt:0,     bin:12, extra_cyc:3,  nwr:10, first_addr:10, last_addr:1,  done_cyc:12, cur_o:0,     bin_o:12, ovf:0};
    vecs[4] = '{cur:2,     bkt:5,     bin:3,  extra_cyc:-1, nwr:0,  first_addr:-1, last_addr:-1, done_cyc:2,  cur_o:5,     bin_o:3,  ovf:0};
    vecs[5] = '{cur:600,   bkt:598,   bin:1,  extra_cyc:-1, nwr:2,  first_addr:88, last_addr:87, done_cyc:4,  cur_o:598,   bin_o:1,  ovf:1};
    vecs[6] = '{cur:4,     bkt:1,     bin:2,  extra_cyc:-1, nwr:3,  first_addr:4,  last_addr:2,  done_cyc:5,  cur_o:1,     bin_o:2,  ovf:1};
    vecs[7] = '{cur:65535, bkt:65535, bin:5,  extra_cyc:-1, nwr:0,  first_addr:-1, last_addr:-1, done_cyc:2,  cur_o:65535, bin_o:5,  ovf:1};

    rst = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_done", done_clear, 0);
    check("reset_we", ram_we_ls_o, 0);
    check("reset_apply", apply_clear_o, 0);
    check("reset_cur_o", cur_lvl_o, 0);
    check("reset_bin_o", load_bin_o, 0);
    check("reset_ovf", lvl_ovf_o, 0);
    rst = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 8; i++) begin
      run_op(vecs[i].cur, vecs[i].bkt, vecs[i].bin, vecs[i].extra_cyc);
      check($sformatf("v%0d_nwrites", i), r_nwr, vecs[i].nwr);
      check($sformatf("v%0d_first_addr", i), r_first, vecs[i].first_addr);
      check($sformatf("v%0d_last_addr", i), r_last, vecs[i].last_addr);
      check($sformatf("v%0d_addr_seq", i), r_addr_err, 0);
      check($sformatf("v%0d_wdata", i), r_data_err, 0);
      check($sformatf("v%0d_apply_align", i), r_apply_err, 0);
      check($sformatf("v%0d_done_cycle", i), r_done_cyc, vecs[i].done_cyc);
      check($sformatf("v%0d_done_count", i), r_done_cnt, 1);
      check($sformatf("v%0d_cur_lvl_o", i), cur_lvl_o, vecs[i].cur_o);
      check($sformatf("v%0d_load_bin_o", i), load_bin_o, vecs[i].bin_o);
      check($sformatf("v%0d_ovf", i), lvl_ovf_o, vecs[i].ovf);
    end

    // Reset in the middle of a clear: cur=8, bkt=0, rst low during cycle 4
    begin
      int wr_seen, done_seen;
      wr_seen = 0; done_seen = 0;
      for (int c = 0; c <= 4; c++) begin
        @(negedge clk);
        if (c > 0 && ram_we_ls_o) wr_seen++;
        start_clear = (c == 0);
        if (c == 0) begin cur_lvl_i = 16'd8; bkt_lvl_i = 16'd0; bkt_bin_i = 10'd6; end
      end
      rst = 1'b0;
      @(negedge clk);
      check("rstmid_writes_before", wr_seen, 3);
      check("rstmid_we", ram_we_ls_o, 0);
      check("rstmid_apply", apply_clear_o, 0);
      check("rstmid_addr", ram_waddr_ls_o, 0);
      check("rstmid_cur_o", cur_lvl_o, 0);
      check("rstmid_bin_o", load_bin_o, 0);
      check("rstmid_ovf", lvl_ovf_o, 0);
      check("rstmid_done", done_clear, 0);
`ifdef LVL_CLR_CNT_EN
      check("rstmid_clr_cnt", clr_cnt_o, 0);
`else
      check("rstmid_wdata", ram_wdata_ls_o, 0);
`endif
      rst = 1'b1;
      wr_seen = 0;
      for (int c = 0; c < 12; c++) begin
        @(negedge clk);
        if (ram_we_ls_o) wr_seen++;
        if (done_clear) done_seen++;
      end
      check("rstmid_no_writes_after", wr_seen, 0);
      check("rstmid_no_done_after", done_seen, 0);
    end

    run_op(5, 2, 7, -1);
    check("fresh_nwrites", r_nwr, 3);
    check("fresh_first_addr", r_first, 5);
    check("fresh_addr_seq", r_addr_err, 0);
    check("fresh_done_cycle", r_done_cyc, 5);
    check("fresh_cur_lvl_o", cur_lvl_o, 2);
    check("fresh_load_bin_o", load_bin_o, 7);
`ifdef LVL_CLR_CNT_EN
    check("fresh_clr_cnt", clr_cnt_o, 3);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
